// File: rtl/alu_pkg.sv
// Shared definitions for the 64-bit LEGv8 ALU: operation codes, data width
// and the bit positions of the NZCV flags.
package alu_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_adder.sv
// Shared 64-bit adder/subtractor: sub inverts b and injects the carry-in,
// so a single carry chain serves both ADD and SUB.
module alu_adder
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              carry,
  output logic              overflow
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   full;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};

  assign sum   = full[DATA_W-1:0];
  assign carry = full[DATA_W];

  // Signed overflow: both adder inputs share a sign the sum does not.
  assign overflow = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/alu.sv
// Combinational 64-bit ALU with zero flag and a registered NZCV status.
// Define ALU_FLAGS_EN to build the flag logic; otherwise flags_q reads 0.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        ALUControl,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic [3:0]        flags_q
);

  logic [DATA_W-1:0] sum;
  logic              carry;
  logic              overflow;
  logic              is_sub;
  logic              is_arith;

  assign is_sub   = (ALUControl == ALU_SUB);
  assign is_arith = (ALUControl == ALU_ADD) || is_sub;

  alu_adder u_adder (
    .a        (a),
    .b        (b),
    .sub      (is_sub),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  always_comb begin
    result = '0;
    case (ALUControl)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD:   result = sum;
      ALU_SUB:   result = sum;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

`ifdef ALU_FLAGS_EN
  logic [3:0] flags_d;

  always_comb begin
    flags_d         = 4'b0000;
    flags_d[FLAG_N] = result[DATA_W-1];
    flags_d[FLAG_Z] = zero;
    flags_d[FLAG_C] = is_arith & carry;
    flags_d[FLAG_V] = is_arith & overflow;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) flags_q <= 4'b0000;
    else          flags_q <= flags_d;
  end
`else
  // Flag logic is not built; these inputs only keep the port list stable.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, reset_n, carry, overflow, is_arith};
  assign flags_q   = 4'b0000;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus queues expected result/zero/flags,
// a monitor checks result/zero each cycle and flags_q one cycle later.
module tb_alu;
  import alu_pkg::*;

`ifdef ALU_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic        rst_n;
    logic [63:0] exp_result;
    logic        exp_zero;
    logic [3:0]  exp_flags;
  } item_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  ALUControl;
  logic [63:0] result;
  logic        zero;
  logic [3:0]  flags_q;

  item_t vecs[$];
  item_t sb[$];
  int    checks = 0;
  int    failures = 0;

  alu dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .result     (result),
    .zero       (zero),
    .flags_q    (flags_q)
  );

  always #5 clk = ~clk;

  function automatic item_t mk(string name, logic [63:0] va, logic [63:0] vb, logic [3:0] op,
                               logic rst_n, logic [63:0] res, logic z, logic [3:0] fl);
    item_t it;
    it.name = name; it.a = va; it.b = vb; it.op = op; it.rst_n = rst_n;
    it.exp_result = res; it.exp_zero = z;
    // Flags are expected clear whenever reset is held or the flag logic is absent.
    it.exp_flags = (FLAGS_EN && rst_n) ? fl : 4'b0000;
    return it;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input item_t it);
    @(posedge clk);
    #1;
    reset_n    = it.rst_n;
    a          = it.a;
    b          = it.b;
    ALUControl = it.op;
    sb.push_back(it);
  endtask

  // Monitor: flags of the previous item first, then result/zero of the current one.
  initial begin
    item_t cur;
    item_t prev;
    bit    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (have_prev)
        checkOutput({prev.name, "/flags_q"}, {60'd0, flags_q}, {60'd0, prev.exp_flags});
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        checkOutput({cur.name, "/result"}, result, cur.exp_result);
        checkOutput({cur.name, "/zero"}, {63'd0, zero}, {63'd0, cur.exp_zero});
        prev      = cur;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    a          = '0;
    b          = '0;
    ALUControl = 4'b0000;

    vecs.push_back(mk("reset_state",  64'd0, 64'd0, ALU_AND, 1'b0, 64'd0, 1'b1, 4'b0000));
    vecs.push_back(mk("and_3_2",      64'd3, 64'd2, ALU_AND, 1'b1, 64'd2, 1'b0, 4'b0000));
    vecs.push_back(mk("and_2_1",      64'd2, 64'd1, ALU_AND, 1'b1, 64'd0, 1'b1, 4'b0100));
    vecs.push_back(mk("or_0_3",       64'd0, 64'd3, ALU_OR,  1'b1, 64'd3, 1'b0, 4'b0000));
    vecs.push_back(mk("or_2_1",       64'd2, 64'd1, ALU_OR,  1'b1, 64'd3, 1'b0, 4'b0000));
    vecs.push_back(mk("add_2_2",      64'd2, 64'd2, ALU_ADD, 1'b1, 64'd4, 1'b0, 4'b0000));
    vecs.push_back(mk("add_150_27",   64'd150, 64'd27, ALU_ADD, 1'b1, 64'd177, 1'b0, 4'b0000));
    vecs.push_back(mk("sub_2_2",      64'd2, 64'd2, ALU_SUB, 1'b1, 64'd0, 1'b1, 4'b0110));
    vecs.push_back(mk("sub_10_3",     64'd10, 64'd3, ALU_SUB, 1'b1, 64'd7, 1'b0, 4'b0010));
    vecs.push_back(mk("passb_2_2",    64'd2, 64'd2, ALU_PASSB, 1'b1, 64'd2, 1'b0, 4'b0000));
    vecs.push_back(mk("passb_100_200", 64'd100, 64'd200, ALU_PASSB, 1'b1, 64'd200, 1'b0, 4'b0000));
    vecs.push_back(mk("add_wrap",     64'hFFFF_FFFF_FFFF_FFFF, 64'd2, ALU_ADD, 1'b1, 64'd1, 1'b0, 4'b0010));
    vecs.push_back(mk("sub_borrow",   64'd0, 64'd1, ALU_SUB, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'b1000));
    vecs.push_back(mk("add_ovf_pos",  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 1'b1,
                      64'h8000_0000_0000_0000, 1'b0, 4'b1001));
    vecs.push_back(mk("mid_reset",    64'd100, 64'd200, ALU_PASSB, 1'b0, 64'd200, 1'b0, 4'b0000));
    vecs.push_back(mk("undef_1111",   64'd5, 64'd5, 4'b1111, 1'b1, 64'd0, 1'b1, 4'b0100));
    vecs.push_back(mk("sub_5_7",      64'd5, 64'd7, ALU_SUB, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'b1000));
    vecs.push_back(mk("add_ovf_neg",  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, ALU_ADD, 1'b1,
                      64'd0, 1'b1, 4'b0111));
    vecs.push_back(mk("sub_ovf",      64'h8000_0000_0000_0000, 64'd1, ALU_SUB, 1'b1,
                      64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 4'b0011));
    vecs.push_back(mk("undef_0011",   64'd5, 64'd3, 4'b0011, 1'b1, 64'd0, 1'b1, 4'b0100));
    vecs.push_back(mk("and_ones",     64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_00F0, ALU_AND, 1'b1,
                      64'h8000_0000_0000_00F0, 1'b0, 4'b1000));

    repeat (2) @(posedge clk);
    foreach (vecs[i]) applyStimulus(vecs[i]);
    repeat (3) @(posedge clk);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d items left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
